// File: rtl/mul_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_sequencer_pkg: opcode constants and FSM state type for mul_sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mul_sequencer_pkg;

  localparam int C_BUS_WIDTH    = 8;
  localparam int C_PREFIX_WIDTH = 2;
  localparam int C_INST_WIDTH   = 3;
  localparam logic [C_PREFIX_WIDTH+C_INST_WIDTH-1:0] C_OP_ADD = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ADD_LO = 3'd2,
    S_ADD_HI = 3'd3,
    S_SHIFT  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_sequencer: unsigned shift-add multiplier using an external ALU       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int BUS_WIDTH    = C_BUS_WIDTH,
  parameter int PREFIX_WIDTH = C_PREFIX_WIDTH,
  parameter int INST_WIDTH   = C_INST_WIDTH,
  parameter logic [PREFIX_WIDTH+INST_WIDTH-1:0] OP_ADD =
    (PREFIX_WIDTH+INST_WIDTH)'(C_OP_ADD)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [BUS_WIDTH-1:0]               mul_a,
  input  logic [BUS_WIDTH-1:0]               mul_b,
  output logic                               busy,
  output logic                               done,
  output logic [2*BUS_WIDTH-1:0]             product,
  output logic [PREFIX_WIDTH+INST_WIDTH-1:0] alu_opcode,
  output logic [BUS_WIDTH-1:0]               alu_a,
  output logic [BUS_WIDTH-1:0]               alu_b,
  output logic                               alu_cin,
  input  logic [BUS_WIDTH-1:0]               alu_y,
  input  logic                               alu_cout
);

  localparam int W = BUS_WIDTH;

  state_e           state_q, state_d;
  logic [2*W-1:0]   p_q, p_d;
  logic [2*W-1:0]   m_q, m_d;
  logic [W-1:0]     q_q, q_d;
  logic             carry_q, carry_d;
  logic [2*W-1:0]   product_q, product_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      carry_q   <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      carry_q   <= carry_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    m_d        = m_q;
    q_d        = q_q;
    carry_d    = carry_q;
    product_d  = product_q;
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {{W{1'b0}}, mul_a};
          q_d     = mul_b;
          p_d     = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Product is captured on the way into DONE so it is valid alongside done.
        if (q_q == '0) begin
          product_d = p_q;
          state_d   = S_DONE;
        end else if (q_q[0]) begin
          state_d = S_ADD_LO;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADD_LO: begin
        alu_opcode       = OP_ADD;
        alu_a            = m_q[W-1:0];
        alu_b            = p_q[W-1:0];
        p_d[W-1:0]       = alu_y;
        carry_d          = alu_cout;
        state_d          = S_ADD_HI;
      end
      S_ADD_HI: begin
        alu_opcode       = OP_ADD;
        alu_a            = m_q[2*W-1:W];
        alu_b            = p_q[2*W-1:W];
        alu_cin          = carry_q;
        p_d[2*W-1:W]     = alu_y;
        state_d          = S_SHIFT;
      end
      S_SHIFT: begin
        m_d     = m_q << 1;
        q_d     = q_q >> 1;
        state_d = S_CHECK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_sequencer: directed vector bench for mul_sequencer with ALU model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mul_sequencer;

  localparam logic [4:0] TB_OP_ADD = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  mul_a = '0;
  logic [7:0]  mul_b = '0;
  logic        busy, done;
  logic [15:0] product;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic        alu_cin, alu_cout;
  logic [8:0]  alu_sum;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Stand-in for the external op_decode/ALU: only the add opcode is modelled.
  always_comb begin
    alu_sum = '0;
    if (alu_opcode == TB_OP_ADD)
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
    alu_y    = alu_sum[7:0];
    alu_cout = alu_sum[8];
  end

  mul_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_y      (alu_y),
    .alu_cout   (alu_cout)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
    int          exp_lat;
    int          exp_adds;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Launch one multiply and follow it cycle by cycle (cycle n = n edges after accept).
  // inj: cycle at which a stray 3*3 start is pulsed; rst_at: cycle whose edge sees rst;
  // start_at_done: present a 5*5 start while done is high.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int inj, input int rst_at, input bit start_at_done,
                        output int lat, output int adds, output bit aborted);
    lat = -1; adds = 0; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; mul_a = a; mul_b = b;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0; mul_a = '0; mul_b = '0;
      if (alu_opcode == TB_OP_ADD) adds++;
      if (rst_at > 0 && n == rst_at) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        lat = n;
        if (start_at_done) begin
          start = 1'b1; mul_a = 8'd5; mul_b = 8'd5;
        end
        break;
      end
      if (n == inj) begin
        start = 1'b1; mul_a = 8'd3; mul_b = 8'd3;
      end
      if (rst_at > 0 && n == rst_at - 1) rst = 1'b1;
    end
    // Ensure done is a single-cycle pulse and the block returns to idle.
    @(negedge clk);
    start = 1'b0; mul_a = '0; mul_b = '0;
    if (!aborted) begin
      check("done_width", done, 0);
      check("idle_after_done", busy, 0);
    end
  endtask

  int  lat, adds;
  bit  ab;

  initial begin
    vecs[0] = '{8'd25,  8'd9,   16'd225,   14, 4};
    vecs[1] = '{8'd255, 8'd255, 16'd65025, 34, 16};
    vecs[2] = '{8'd0,   8'd7,   16'd0,     14, 6};
    vecs[3] = '{8'd200, 8'd0,   16'd0,     2,  0};
    vecs[4] = '{8'd1,   8'd1,   16'd1,     6,  2};
    vecs[5] = '{8'd128, 8'd2,   16'd256,   8,  2};
    vecs[6] = '{8'd170, 8'd85,  16'd14450, 24, 8};

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    check("reset_opcode", alu_opcode, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, 1'b0, lat, adds, ab);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_product", i), product, vecs[i].exp_p);
      check($sformatf("v%0d_add_cycles", i), adds, vecs[i].exp_adds);
    end

    // Product holds while idle.
    repeat (4) @(negedge clk);
    check("product_hold", product, 16'd14450);

    // Start while busy is ignored.
    run_op(8'd25, 8'd9, 5, 0, 1'b0, lat, adds, ab);
    check("busy_start_latency", lat, 14);
    check("busy_start_product", product, 225);
    repeat (2) @(negedge clk);
    check("busy_start_no_rerun", busy, 0);

    // Start presented during DONE is ignored.
    run_op(8'd1, 8'd1, 0, 0, 1'b1, lat, adds, ab);
    check("done_start_latency", lat, 6);
    check("done_start_product", product, 1);
    repeat (3) @(negedge clk);
    check("done_start_still_idle", busy, 0);

    // Reset mid-operation, then a clean run.
    run_op(8'd255, 8'd255, 0, 6, 1'b0, lat, adds, ab);
    check("abort_flag", ab, 1);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) begin
        check("abort_no_done", 1, 0);
        break;
      end
    end
    run_op(8'd12, 8'd12, 0, 0, 1'b0, lat, adds, ab);
    check("after_rst_latency", lat, 14);
    check("after_rst_product", product, 144);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, giving the operand width and the ALU data width.
REQ-002 The block SHALL have parameter PREFIX_WIDTH, default 2, giving the opcode prefix field width.
REQ-003 The block SHALL have parameter INST_WIDTH, default 3, giving the opcode instruction field width.
REQ-004 The block SHALL have parameter OP_ADD, default 5'b10000, giving the ALU add opcode: Y = A + B + Cin, with carry-out on Cout.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port start, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-009 Port mul_a, input, BUS_WIDTH bits: unsigned multiplicand; sampled with start.
REQ-010 Port mul_b, input, BUS_WIDTH bits: unsigned multiplier; sampled with start.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse marking product valid.
REQ-013 Port product, output, 2*BUS_WIDTH bits: registered result.
REQ-014 Port alu_opcode, output, PREFIX_WIDTH+INST_WIDTH bits: opcode driven to the external op_decode.
REQ-015 Ports alu_a and alu_b, output, BUS_WIDTH bits each: ALU operands.
REQ-016 Port alu_cin, output, 1 bit: ALU carry-in.
REQ-017 Ports alu_y (input, BUS_WIDTH bits) and alu_cout (input, 1 bit): combinational ALU result and carry, sampled in the same cycle they are driven.

Function
REQ-018 The algorithm SHALL be unsigned shift-add: P=0, M=zero-extended mul_a (2*BUS_WIDTH bits), Q=mul_b; all additions go through the ALU, while shifts stay in internal registers.
REQ-019 The states SHALL be IDLE, CHECK, ADD_LO, ADD_HI, SHIFT and DONE.
REQ-020 In IDLE, start=1 SHALL latch M, Q, clear P, and move to CHECK; start=0 SHALL hold IDLE.
REQ-021 CHECK SHALL go to DONE when Q==0, to ADD_LO when Q[0]=1, and to SHIFT otherwise.
REQ-022 ADD_LO SHALL drive opcode=OP_ADD, A=M[low], B=P[low], Cin=0, then register P[low]<=alu_y and carry<=alu_cout, then go to ADD_HI.
REQ-023 ADD_HI SHALL drive opcode=OP_ADD, A=M[high], B=P[high], Cin=stored carry, then register P[high]<=alu_y (final carry discarded), then go to SHIFT.
REQ-024 SHIFT SHALL set M<<=1 and Q>>=1 (logical), then go to CHECK.
REQ-025 DONE SHALL set product<=P (registered on entry so it is valid while done=1), assert done for exactly one cycle, then go to IDLE.
REQ-026 Outside ADD_LO and ADD_HI, alu_opcode, alu_a, alu_b and alu_cin SHALL be 0.
REQ-027 Latency: with k = index of the highest set bit of mul_b plus 1 (k=0 when mul_b=0) and p = popcount(mul_b), done SHALL be high in cycle 2+2k+2p after the start-accept edge.
REQ-028 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-029 product SHALL hold its value until the next DONE.
REQ-030 start in the same cycle as DONE SHALL be ignored; start is accepted from the following IDLE cycle.

Reset
REQ-031 When rst=1 at a rising edge, the block SHALL go to IDLE and clear busy, done, product, P, M, Q, carry and all ALU drive outputs to 0.
REQ-032 Reset SHALL take priority over start and over any in-progress state; no done pulse is produced for an aborted operation.

Structure
REQ-033 A shared package SHALL hold the opcode constants (OP_ADD and the field widths) and the state encoding type.
REQ-034 There SHALL be no sub-module; op_decode stays external and is connected at the integration level and by the bench.

Verification
REQ-035 The bench SHALL drive mul_a=25, mul_b=9 -> product=225, with done in cycle 14 after accept.
REQ-036 The bench SHALL drive mul_a=255, mul_b=255 -> product=65025, with done in cycle 34 (exercises the low-to-high carry).
REQ-037 The bench SHALL drive mul_a=0, mul_b=7 -> product=0, and mul_a=200, mul_b=0 -> product=0 with done in cycle 2.
REQ-038 The bench SHALL drive 25*9, then pulse start with 3*3 at cycle 5 -> the second start is ignored and product=225.
REQ-039 The bench SHALL assert rst at cycle 6 of 255*255 -> busy, done and product are 0 next cycle, and a subsequent 12*12 gives 144.
